// File: rtl/multi_timer.sv
// Multi-channel down-counting timer: per-channel prescaler, reload, one-shot/periodic, sticky pending.
// Define MULTI_TIMER_CASCADE_EN to implement CTRL[3] CASC (channel c ticks on channel c-1 expiry).
module multi_timer #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic [1:0]  sel_i,
    input  logic        rd_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        interrupt
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [N_CH-1:0]    en_q;
    logic [N_CH-1:0]    en_d;
    logic [N_CH-1:0]    per_q;
    logic [N_CH-1:0]    per_d;
    logic [N_CH-1:0]    ie_q;
    logic [N_CH-1:0]    ie_d;
    logic [N_CH-1:0]    casc_q;
    logic [N_CH-1:0]    casc_d;
    logic [N_CH-1:0]    pend_q;
    logic [N_CH-1:0]    pend_d;
    logic [PRESC_W-1:0] presc_q [N_CH];
    logic [PRESC_W-1:0] presc_d [N_CH];
    logic [PRESC_W-1:0] pc_q    [N_CH];
    logic [PRESC_W-1:0] pc_d    [N_CH];
    logic [WIDTH-1:0]   load_q  [N_CH];
    logic [WIDTH-1:0]   load_d  [N_CH];
    logic [WIDTH-1:0]   count_q [N_CH];
    logic [WIDTH-1:0]   count_d [N_CH];
    logic [31:0]        word_s  [N_CH];

    logic [3:0] ch_sel_s;
    logic [1:0] reg_sel_s;
    logic       unused_s;

    assign ch_sel_s  = addr_i[7:4];
    assign reg_sel_s = addr_i[3:2];
    assign ack_o     = 1'b1;
    assign interrupt = |(pend_q & ie_q);
    // Access size and read strobe carry no information: every access is a full word.
    assign unused_s  = ^{addr_i, data_i, sel_i, rd_i};

    // Next-state for all channels; expiry ripples upward so a cascaded channel ticks in the same cycle.
    always_comb begin : next_state
        logic prev_exp_s;
        logic wr_ch_s;
        logic use_casc_s;
        logic hit_s;
        logic tick_s;
        logic cnt_wr_s;
        logic exp_s;
        prev_exp_s = 1'b0;
        wr_ch_s    = 1'b0;
        use_casc_s = 1'b0;
        hit_s      = 1'b0;
        tick_s     = 1'b0;
        cnt_wr_s   = 1'b0;
        exp_s      = 1'b0;
        en_d       = en_q;
        per_d      = per_q;
        ie_d       = ie_q;
        casc_d     = casc_q;
        pend_d     = pend_q;
        presc_d    = presc_q;
        pc_d       = pc_q;
        load_d     = load_q;
        count_d    = count_q;
        for (int c = 0; c < N_CH; c++) begin
            wr_ch_s    = we_i && (ch_sel_s == 4'(c));
            use_casc_s = 1'b0;
`ifdef MULTI_TIMER_CASCADE_EN
            if (c > 0) begin
                use_casc_s = casc_q[c];
            end else begin
                use_casc_s = 1'b0;
            end
`endif
            hit_s = (pc_q[c] == presc_q[c]);
            if (use_casc_s) begin
                tick_s = en_q[c] && prev_exp_s;
            end else begin
                tick_s = en_q[c] && hit_s;
            end
            // A bus write to COUNT replaces the whole tick action, expiry included.
            cnt_wr_s = wr_ch_s && (reg_sel_s == REG_COUNT);
            exp_s    = tick_s && !cnt_wr_s && (count_q[c] == WIDTH'(1));

            if (wr_ch_s && (reg_sel_s == REG_CTRL)) begin
                pc_d[c] = {PRESC_W{1'b0}};
            end else if (!en_q[c] || use_casc_s || hit_s) begin
                pc_d[c] = {PRESC_W{1'b0}};
            end else begin
                pc_d[c] = pc_q[c] + PRESC_W'(1);
            end

            if (cnt_wr_s) begin
                count_d[c] = data_i[WIDTH-1:0];
            end else if (exp_s) begin
                if (per_q[c]) begin
                    count_d[c] = load_q[c];
                end else begin
                    count_d[c] = {WIDTH{1'b0}};
                end
            end else if (tick_s && (count_q[c] > WIDTH'(1))) begin
                count_d[c] = count_q[c] - WIDTH'(1);
            end else begin
                count_d[c] = count_q[c];
            end

            if (wr_ch_s && (reg_sel_s == REG_LOAD)) begin
                load_d[c] = data_i[WIDTH-1:0];
            end else begin
                load_d[c] = load_q[c];
            end

            if (exp_s) begin
                pend_d[c] = 1'b1;
            end else if (wr_ch_s && (reg_sel_s == REG_STATUS) && data_i[0]) begin
                pend_d[c] = 1'b0;
            end else begin
                pend_d[c] = pend_q[c];
            end

            if (wr_ch_s && (reg_sel_s == REG_CTRL)) begin
                en_d[c]    = data_i[0];
                per_d[c]   = data_i[1];
                ie_d[c]    = data_i[2];
                presc_d[c] = data_i[8 +: PRESC_W];
`ifdef MULTI_TIMER_CASCADE_EN
                casc_d[c]  = data_i[3];
`else
                casc_d[c]  = 1'b0;
`endif
            end else if (exp_s && !per_q[c]) begin
                en_d[c] = 1'b0;
            end else begin
                en_d[c] = en_q[c];
            end

            prev_exp_s = exp_s;
        end
    end

    // Per-channel register words with unused high bits forced to zero.
    always_comb begin : chan_words
        for (int c = 0; c < N_CH; c++) begin
            word_s[c] = 32'h0;
            case (reg_sel_s)
                REG_CTRL: begin
                    word_s[c][0]             = en_q[c];
                    word_s[c][1]             = per_q[c];
                    word_s[c][2]             = ie_q[c];
                    word_s[c][3]             = casc_q[c];
                    word_s[c][8 +: PRESC_W]  = presc_q[c];
                end
                REG_LOAD:   word_s[c][WIDTH-1:0] = load_q[c];
                REG_COUNT:  word_s[c][WIDTH-1:0] = count_q[c];
                REG_STATUS: word_s[c][0]         = pend_q[c];
                default:    word_s[c]            = 32'h0;
            endcase
        end
    end

    // Read mux; channel indices at or above N_CH match nothing and read zero.
    always_comb begin : read_mux
        logic [31:0] acc_s;
        acc_s = 32'h0;
        for (int c = 0; c < N_CH; c++) begin
            acc_s = (ch_sel_s == 4'(c)) ? word_s[c] : acc_s;
        end
        data_o = acc_s;
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= {N_CH{1'b0}};
            per_q  <= {N_CH{1'b0}};
            ie_q   <= {N_CH{1'b0}};
            casc_q <= {N_CH{1'b0}};
            pend_q <= {N_CH{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                presc_q[c] <= {PRESC_W{1'b0}};
                pc_q[c]    <= {PRESC_W{1'b0}};
                load_q[c]  <= {WIDTH{1'b0}};
                count_q[c] <= {WIDTH{1'b0}};
            end
        end else begin
            en_q    <= en_d;
            per_q   <= per_d;
            ie_q    <= ie_d;
            casc_q  <= casc_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            load_q  <= load_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed and randomized bench for multi_timer against a behavioural channel model.
module tb_multi_timer;

    localparam int N_CH    = 4;
    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;
    localparam int unsigned WMASK = 32'h0000_FFFF;
`ifdef MULTI_TIMER_CASCADE_EN
    localparam bit CASC_EN = 1'b1;
`else
    localparam bit CASC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_o;
    logic [31:0] data_i = 32'h0;
    logic [1:0]  sel_i = 2'b00;
    logic        rd_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        interrupt;

    int checks = 0;
    int failures = 0;

    bit          m_en    [N_CH];
    bit          m_per   [N_CH];
    bit          m_ie    [N_CH];
    bit          m_casc  [N_CH];
    bit          m_pend  [N_CH];
    int unsigned m_presc [N_CH];
    int unsigned m_pc    [N_CH];
    int unsigned m_load  [N_CH];
    int unsigned m_count [N_CH];

    multi_timer #(.N_CH(N_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_o(data_o), .data_i(data_i),
        .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i), .ack_o(ack_o), .interrupt(interrupt)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_en[c] = 1'b0; m_per[c] = 1'b0; m_ie[c] = 1'b0; m_casc[c] = 1'b0; m_pend[c] = 1'b0;
            m_presc[c] = 0; m_pc[c] = 0; m_load[c] = 0; m_count[c] = 0;
        end
    endtask

    // One clock edge of the specification's rules, all decisions taken from pre-edge state.
    task automatic model_clock(input bit we, input logic [31:0] a, input logic [31:0] d);
        int ch;
        int r;
        bit carry_in;
        ch = int'(a[7:4]);
        r  = int'(a[3:2]);
        carry_in = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            bit mine;
            bit cascaded;
            bit presc_done;
            bit tick;
            bit expired;
            mine       = we && (ch == c);
            cascaded   = CASC_EN && (c > 0) && m_casc[c];
            presc_done = (m_pc[c] == m_presc[c]);
            tick       = m_en[c] && (cascaded ? carry_in : presc_done);
            expired    = tick && (m_count[c] == 1) && !(mine && r == 2);
            if ((mine && r == 0) || !m_en[c] || cascaded || presc_done) m_pc[c] = 0;
            else m_pc[c] = m_pc[c] + 1;
            if (mine && r == 2) m_count[c] = d & WMASK;
            else if (expired) m_count[c] = m_per[c] ? m_load[c] : 0;
            else if (tick && m_count[c] > 1) m_count[c] = m_count[c] - 1;
            if (mine && r == 1) m_load[c] = d & WMASK;
            if (expired) m_pend[c] = 1'b1;
            else if (mine && r == 3 && d[0]) m_pend[c] = 1'b0;
            if (mine && r == 0) begin
                m_en[c]    = d[0];
                m_per[c]   = d[1];
                m_ie[c]    = d[2];
                m_casc[c]  = CASC_EN && d[3];
                m_presc[c] = (d >> 8) & 32'hFF;
            end else if (expired && !m_per[c]) begin
                m_en[c] = 1'b0;
            end
            carry_in = expired;
        end
    endtask

    function automatic logic [31:0] model_read(input int ch, input int r);
        logic [31:0] v;
        v = 32'h0;
        if (ch < N_CH) begin
            case (r)
                0: v = 32'(m_en[ch]) | (32'(m_per[ch]) << 1) | (32'(m_ie[ch]) << 2)
                       | (32'(m_casc[ch]) << 3) | (32'(m_presc[ch]) << 8);
                1: v = m_load[ch];
                2: v = m_count[ch];
                3: v = 32'(m_pend[ch]);
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    function automatic logic model_irq();
        logic any;
        any = 1'b0;
        for (int c = 0; c < N_CH; c++) any = any | (m_pend[c] & m_ie[c]);
        return any;
    endfunction

    task automatic cycle(input bit we, input int ch, input int r, input logic [31:0] d);
        logic [31:0] a;
        a = {24'h0, 4'(ch), 2'(r), 2'b00};
        addr_i = a; data_i = d; we_i = we; rd_i = 1'b0;
        sel_i = 2'($urandom_range(0, 3));
        @(posedge clk);
        model_clock(we, a, d);
        #1;
        we_i = 1'b0;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        cycle(1'b1, ch, r, d);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 32'h0);
    endtask

    task automatic peek(input int ch, input int r);
        addr_i = {24'h0, 4'(ch), 2'(r), 2'b00};
        rd_i = 1'b1;
        #1;
        rd_i = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input int ch, input int r);
        peek(ch, r);
        check(tag, data_o, model_read(ch, r));
    endtask

    task automatic chk_const(input string tag, input int ch, input int r, input logic [31:0] exp);
        peek(ch, r);
        check(tag, data_o, exp);
    endtask

    task automatic chk_irq(input string tag);
        check(tag, {31'h0, interrupt}, {31'h0, model_irq()});
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int wch;
        int wr_r;
        int rch;
        bit wen;
        logic [31:0] wd;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        for (int c = 0; c < N_CH; c++)
            for (int r = 0; r < 4; r++) chk_const("reset_reg", c, r, 32'h0);
        check("reset_ack", {31'h0, ack_o}, 32'h1);
        check("reset_irq", {31'h0, interrupt}, 32'h0);

        // 1: asynchronous reset mid-run
        wr(0, 1, 32'd5); wr(0, 2, 32'd5); wr(0, 0, 32'h3);
        idle(); idle();
        chk_const("t1_count_run", 0, 2, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_const("t1_count_rst", 0, 2, 32'h0);
        chk_const("t1_ctrl_rst", 0, 0, 32'h0);
        check("t1_irq_rst", {31'h0, interrupt}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // 2: periodic with prescaler 1, pending every 6 cycles, cleared at cycle 7
        wr(1, 1, 32'd3); wr(1, 2, 32'd3); wr(1, 0, 32'h107);
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) wr(1, 3, 32'h1);
            else idle();
            chk_const("t2_pend", 1, 3, (k == 6 || k == 12) ? 32'h1 : 32'h0);
            check("t2_irq", {31'h0, interrupt}, (k == 6 || k == 12) ? 32'h1 : 32'h0);
            chk_reg("t2_count", 1, 2);
            if (k == 6) chk_const("t2_reload", 1, 2, 32'd3);
        end
        wr(1, 0, 32'h0); wr(1, 3, 32'h1);

        // 3: one-shot self-disable
        wr(2, 2, 32'd2); wr(2, 0, 32'h5);
        idle();
        chk_const("t3_pend_k1", 2, 3, 32'h0);
        chk_const("t3_count_k1", 2, 2, 32'd1);
        idle();
        chk_const("t3_pend_k2", 2, 3, 32'h1);
        chk_const("t3_count_k2", 2, 2, 32'h0);
        chk_const("t3_ctrl_k2", 2, 0, 32'h4);
        check("t3_irq", {31'h0, interrupt}, 32'h1);
        wr(2, 3, 32'h1);
        for (int k = 0; k < 20; k++) begin
            idle();
            chk_const("t3_quiet_pend", 2, 3, 32'h0);
            chk_const("t3_quiet_count", 2, 2, 32'h0);
        end
        // CTRL write coincident with one-shot expiry keeps EN
        wr(2, 2, 32'd1); wr(2, 0, 32'h1);
        wr(2, 0, 32'h1);
        chk_const("t3_ctrl_wins", 2, 0, 32'h1);
        chk_const("t3_ctrl_pend", 2, 3, 32'h1);
        chk_const("t3_ctrl_count", 2, 2, 32'h0);
        chk_irq("t3_ctrl_irq");
        wr(2, 0, 32'h0); wr(2, 3, 32'h1);

        // 4: collisions
        wr(3, 2, 32'd1); wr(3, 0, 32'h3);
        wr(3, 3, 32'h1);
        chk_const("t4_pend_kept", 3, 3, 32'h1);
        chk_const("t4_count_load0", 3, 2, 32'h0);
        wr(3, 2, 32'd5);
        idle();
        chk_const("t4_count_dec", 3, 2, 32'd4);
        wr(3, 2, 32'd7);
        chk_const("t4_count_wr_wins", 3, 2, 32'd7);
        idle();
        chk_const("t4_count_after", 3, 2, 32'd6);
        wr(3, 0, 32'h0); wr(3, 3, 32'h1);

        // 5: decode and truncation
        for (int r = 0; r < 4; r++) wr(4, r, 32'hFFFF_FFFF);
        for (int r = 0; r < 4; r++) begin
            chk_const("t5_ch4_zero", 4, r, 32'h0);
            chk_const("t5_ch15_zero", 15, r, 32'h0);
        end
        for (int c = 0; c < N_CH; c++)
            for (int r = 0; r < 4; r++) chk_reg("t5_no_change", c, r);
        chk_const("t5_status_hi", 0, 3, 32'h0);
        wr(0, 1, 32'hFFFF_FFFF);
        chk_const("t5_load_trunc", 0, 1, 32'h0000_FFFF);
        wr(0, 0, 32'hFFFF_FFFF);
        chk_const("t5_ctrl_bits", 0, 0, CASC_EN ? 32'h0000_FF0F : 32'h0000_FF07);
        wr(0, 0, 32'h0);

`ifdef MULTI_TIMER_CASCADE_EN
        // 6: cascade ch1 on ch0 expiry
        pulse_reset();
        wr(1, 2, 32'd2); wr(1, 0, 32'h9);
        wr(0, 1, 32'd4); wr(0, 2, 32'd4); wr(0, 0, 32'h3);
        for (int k = 1; k <= 8; k++) begin
            idle();
            chk_const("t6_ch0_pend", 0, 3, (k >= 4) ? 32'h1 : 32'h0);
            chk_const("t6_ch1_pend", 1, 3, (k == 8) ? 32'h1 : 32'h0);
            chk_reg("t6_ch1_count", 1, 2);
        end
`endif

        // randomized traffic against the model
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            wen  = 1'($urandom_range(0, 1));
            wch  = int'($urandom_range(0, 4));
            wr_r = int'($urandom_range(0, 3));
            case (wr_r)
                0: wd = {16'h0, 8'($urandom_range(0, 3)), 4'h0, 4'($urandom_range(0, 15))};
                1, 2: wd = 32'($urandom_range(0, 6)) | ({$urandom} & 32'hFFFF_0000 & {32{i[3]}});
                default: wd = $urandom;
            endcase
            cycle(wen, wch, wr_r, wd);
            rch = int'($urandom_range(0, 4));
            for (int r = 0; r < 4; r++) chk_reg("rand_reg", rch, r);
            chk_irq("rand_irq");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised multi-channel down-counting timer; successor to the single 32-bit countdown timer on the system bus.
- Each channel adds a prescaler, a reload register, one-shot/periodic mode, interrupt enable and a sticky pending flag.
- Sits on the peripheral bus as a slave. Drives one interrupt line to the interrupt controller, which is the OR of all enabled pending flags.

Parameters:
N_CH, 4, number of channels (1..16)
WIDTH, 32, counter/reload width in bits (1..32)
PRESC_W, 8, prescaler field width (1..16)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
addr_i  input  32  byte address; [3:2] register select, [7:4] channel select
data_o  output  32  read data, combinational from addr_i
data_i  input  32  write data
sel_i  input  2  access size; ignored, all accesses are full word
rd_i  input  1  read strobe
we_i  input  1  write strobe, single-cycle
ack_o  output  1  tied 1, zero-wait-state
interrupt  output  1  OR over channels of (PEND & IE)

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset: all registers 0, including CTRL, LOAD, COUNT, PEND and the prescaler counters.
  - Outputs after reset: interrupt=0, data_o reflects the zeroed registers, ack_o=1.
- Register map per channel c:
  - 0x0 CTRL: [0] EN, [1] PERIODIC, [2] IE, [3] CASC (optional), [8+:PRESC_W] PRESC.
  - 0x4 LOAD: reload value, WIDTH bits.
  - 0x8 COUNT: current count, WIDTH bits. A write loads the counter directly.
  - 0xC STATUS: [0] PEND. Write 1 clears; write 0 has no effect.
- Channel decode:
  - Channel index c >= N_CH: writes ignored, reads return 0.
  - Unused high bits read 0. Data is truncated to field width on write.
- Prescaler: per-channel counter pc.
  - When EN=1: pc==PRESC gives tick=1 and pc<=0; otherwise pc<=pc+1.
  - PRESC=0 gives a tick every cycle. Tick period is PRESC+1 cycles.
  - EN=0 holds pc at 0. Any CTRL write clears pc.
- Tick action, applied only when EN=1:
  - COUNT>1: COUNT<=COUNT-1.
  - COUNT==1 (expiry):
    - PEND<=1.
    - PERIODIC=1: COUNT<=LOAD.
    - PERIODIC=0: COUNT<=0 and EN<=0 (one-shot self-disable).
  - COUNT==0: no change, no event.
- Period: periodic mode with LOAD=L expires every L*(PRESC+1) cycles once running. LOAD=0 stops the channel after the next expiry.
- Priority within one cycle:
  - Bus write to COUNT beats tick action.
  - Expiry setting PEND beats a STATUS clear in the same cycle, so no event is lost.
  - Bus write to CTRL beats the one-shot EN clear.
- Arithmetic: no wrap. Underflow is impossible because COUNT==0 never decrements.
- interrupt: combinational from registered PEND/IE, updated the cycle after PEND sets.
- Reset mid-count: all state returns to 0 immediately (asynchronous); interrupt deasserts.

Optional Feature:
- Macro: MULTI_TIMER_CASCADE_EN.
- Defined: CTRL[3] CASC is implemented.
  - Channel c>0 with CASC=1 ticks on the expiry of channel c-1 (same cycle) instead of its own prescaler; its pc is held at 0.
  - CASC on channel 0 has no effect.
  - Allows chained counters wider than WIDTH.
- Undefined: CTRL[3] reads 0, writes are ignored, all channels use their own prescaler.

Test Plan:
1. Reset mid-run: ch0 LOAD=5, COUNT=5, CTRL=EN|PERIODIC; assert rst at cycle 3 -> COUNT, CTRL and pc read 0 with no clock edge needed; interrupt=0.
2. Periodic with prescaler: ch1 LOAD=3, COUNT=3, PRESC=1, CTRL=EN|PERIODIC|IE -> PEND sets every 6 cycles and COUNT reloads to 3; interrupt=1; STATUS write 1 -> interrupt=0 next cycle.
3. One-shot: ch2 COUNT=2, PRESC=0, CTRL=EN|IE -> PEND=1 two cycles after enable, COUNT=0, CTRL.EN reads 0, no further events over 20 cycles.
4. Collisions: STATUS clear coincident with expiry -> PEND stays 1. COUNT write of 7 coincident with tick -> COUNT reads 7.
5. Decode: write to channel index N_CH, and reads of unused bits -> no state change, data_o=0; LOAD write of 0xFFFFFFFF with WIDTH=16 -> reads 0x0000FFFF.
6. Cascade (MULTI_TIMER_CASCADE_EN): ch0 periodic LOAD=4, PRESC=0; ch1 CASC=1, COUNT=2, EN=1 -> ch1 PEND after 8 cycles; with the macro undefined, CTRL[3] reads 0.
